// File: rtl/led_out_port_if.sv
// Data-memory bus as seen by the LED output port: store strobe, address and data,
// plus the held word returned for the core's load mux.
interface led_out_port_if;
   logic        mem_write;
   logic [31:0] data_adr;
   logic [31:0] write_data;
   logic [31:0] led_word;

   modport master (
      output mem_write,
      output data_adr,
      output write_data,
      input  led_word
   );

   modport slave (
      input  mem_write,
      input  data_adr,
      input  write_data,
      output led_word
   );
endinterface

// File: rtl/led_out_port.sv
// Memory-mapped LED register: latches stores to LED_ADDR and drives 8 LEDs from a
// byte window chosen by a synchronized, debounced board switch.
module led_out_port #(
   parameter logic [31:0] LED_ADDR        = 32'h0000_0100,
   parameter int unsigned DEBOUNCE_CYCLES = 50000,
   parameter int unsigned CNT_W           = 16
) (
   input  logic           clk,
   input  logic           reset,
   led_out_port_if.slave  bus,
   input  logic           switch,
   output logic [7:0]     led_output,
   output logic [7:0]     write_count
);

   localparam int unsigned WORD_W = 32;
   localparam int unsigned LED_W  = 8;

   logic [WORD_W-1:0] held_word;
   logic              sync_ff1;
   logic              sync_ff2;
   logic              sw_stable;
   logic [CNT_W-1:0]  deb_cnt;

   logic              store_hit_c;
   logic [LED_W-1:0]  byte_a_c;
   logic [LED_W-1:0]  byte_b_c;
   logic              adr_lsb_unused;

   // Word-aligned decode; byte offset within the word is don't-care.
   assign store_hit_c    = bus.mem_write && (bus.data_adr[31:2] == LED_ADDR[31:2]);
   assign adr_lsb_unused = ^bus.data_adr[1:0];

   // byte_b straddles byte_a on purpose so both switch positions show the top nibble area.
   assign byte_a_c     = held_word[31:24];
   assign byte_b_c     = held_word[27:20];
   assign bus.led_word = held_word;

   // Store capture and accepted-store counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         held_word   <= '0;
         write_count <= '0;
      end else if (store_hit_c) begin
         held_word   <= bus.write_data;
         write_count <= write_count + 8'd1;
      end
   end

   // Two-flop synchronizer for the asynchronous switch.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync_ff1 <= 1'b0;
         sync_ff2 <= 1'b0;
      end else begin
         sync_ff1 <= switch;
         sync_ff2 <= sync_ff1;
      end
   end

   // A change is accepted only after it persists DEBOUNCE_CYCLES consecutive edges.
   always_ff @(posedge clk) begin
      if (reset) begin
         sw_stable <= 1'b0;
         deb_cnt   <= '0;
      end else if (sync_ff2 == sw_stable) begin
         deb_cnt <= '0;
      end else if (deb_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
         sw_stable <= sync_ff2;
         deb_cnt   <= '0;
      end else begin
         deb_cnt <= deb_cnt + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         led_output <= '0;
      end else begin
         led_output <= sw_stable ? byte_a_c : byte_b_c;
      end
   end

endmodule

// File: tb/tb_led_out_port.sv
// Directed bench for led_out_port with a short debounce window.
module tb_led_out_port;

   localparam int unsigned DEB = 4;

   logic       clk;
   logic       reset;
   logic       switch;
   logic [7:0] led_output;
   logic [7:0] write_count;

   int unsigned n_checks;
   int unsigned n_pass;

   led_out_port_if bus ();

   led_out_port #(
      .LED_ADDR        (32'h0000_0100),
      .DEBOUNCE_CYCLES (DEB),
      .CNT_W           (16)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .bus         (bus.slave),
      .switch      (switch),
      .led_output  (led_output),
      .write_count (write_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one rising edge; inputs are driven and outputs sampled 1 time unit later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   task automatic store(input logic [31:0] adr, input logic [31:0] data, input logic we);
      bus.mem_write  = we;
      bus.data_adr   = adr;
      bus.write_data = data;
      tick();
      bus.mem_write  = 1'b0;
   endtask

   initial begin
      n_checks       = 0;
      n_pass         = 0;
      reset          = 1'b1;
      switch         = 1'b0;
      bus.mem_write  = 1'b0;
      bus.data_adr   = '0;
      bus.write_data = '0;
      tick();
      tick();
      reset = 1'b0;
      repeat (5) tick();
      chk("rst_led",   32'(led_output),  32'h0);
      chk("rst_word",  bus.led_word,     32'h0);
      chk("rst_count", 32'(write_count), 32'h0);

      // First store, switch low selects bits [27:20].
      store(32'h100, 32'hA5C3_0000, 1'b1);
      chk("st1_word",  bus.led_word,     32'hA5C3_0000);
      chk("st1_count", 32'(write_count), 32'd1);
      chk("st1_led_early", 32'(led_output), 32'h00);
      tick();
      chk("st1_led", 32'(led_output), 32'h5C);

      // Switch rises: 2 sync + DEB debounce + 1 output edges.
      switch = 1'b1;
      for (int i = 1; i <= 2 + DEB; i++) begin
         tick();
         chk($sformatf("sw_hold_%0d", i), 32'(led_output), 32'h5C);
      end
      tick();
      chk("sw_rise", 32'(led_output), 32'hA5);
      tick();
      chk("sw_steady", 32'(led_output), 32'hA5);

      switch = 1'b0;
      repeat (2 + DEB + 1) tick();
      chk("sw_fall", 32'(led_output), 32'h5C);

      // Two-cycle glitch never completes the count.
      switch = 1'b1;
      repeat (2) tick();
      switch = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick();
         chk($sformatf("glitch_%0d", i), 32'(led_output), 32'h5C);
      end

      // Address decode and strobe qualification.
      store(32'h104, 32'hFFFF_FFFF, 1'b1);
      chk("miss_adr_word",  bus.led_word,     32'hA5C3_0000);
      chk("miss_adr_count", 32'(write_count), 32'd1);
      store(32'h100, 32'hFFFF_FFFF, 1'b0);
      chk("no_we_word",  bus.led_word,     32'hA5C3_0000);
      chk("no_we_count", 32'(write_count), 32'd1);
      store(32'h102, 32'h1234_5678, 1'b1);
      chk("lsb_word",  bus.led_word,     32'h1234_5678);
      chk("lsb_count", 32'(write_count), 32'd2);
      tick();
      chk("lsb_led", 32'(led_output), 32'h23);

      // Back-to-back stores: bring count to 0 through the 255->0 wrap, then a full lap.
      bus.mem_write = 1'b1;
      bus.data_adr  = 32'h100;
      for (int i = 0; i < 254; i++) begin
         bus.write_data = 32'(i);
         tick();
      end
      bus.mem_write = 1'b0;
      chk("wrap_count", 32'(write_count), 32'd0);
      chk("wrap_word",  bus.led_word,     32'd253);
      bus.mem_write = 1'b1;
      for (int i = 0; i < 256; i++) begin
         bus.write_data = 32'hC0DE_0000 + 32'(i);
         tick();
      end
      bus.mem_write = 1'b0;
      chk("lap_count", 32'(write_count), 32'd0);
      chk("lap_word",  bus.led_word,     32'hC0DE_00FF);

      // Reset while the debounce counter sits at 2.
      store(32'h100, 32'hA5C3_0000, 1'b1);
      tick();
      chk("pre_rst_led", 32'(led_output), 32'h5C);
      switch = 1'b1;
      repeat (4) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("mid_rst_led",   32'(led_output),  32'h0);
      chk("mid_rst_word",  bus.led_word,     32'h0);
      chk("mid_rst_count", 32'(write_count), 32'h0);
      store(32'h100, 32'hA5C3_0000, 1'b1);
      chk("post_rst_count", 32'(write_count), 32'd1);
      for (int i = 2; i <= 2 + DEB; i++) begin
         tick();
         chk($sformatf("post_rst_hold_%0d", i), 32'(led_output), 32'h5C);
      end
      tick();
      chk("post_rst_rise", 32'(led_output), 32'hA5);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
